// File: rtl/enduro_rd_ptr_empty.sv
// Read-side pointer and flag logic for an asynchronous FIFO.
// Keeps the binary/Gray read pointer and derives empty, almost_empty,
// occupancy and a sticky underflow flag against the synchronized write pointer.
module enduro_rd_ptr_empty #(
    parameter int ADDR_WIDTH          = 4,
    parameter int ALMOST_EMPTY_THRESH = 2
) (
    input  logic                  dst_clk,
    input  logic                  dst_reset,
    input  logic                  domain_ready,
    input  logic [ADDR_WIDTH:0]   wr_gray_synced,
    input  logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [ADDR_WIDTH:0]   rd_gray,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   rd_count,
    output logic                  underflow
);

    localparam int PW = ADDR_WIDTH + 1;

    typedef enum logic {INIT, ACTIVE} state_t;

    state_t          state, state_next;
    logic [PW-1:0]   rd_bin, rd_bin_next, rd_gray_next;
    logic [PW-1:0]   wr_bin, count_next;
    logic            rd_fire, empty_next, almost_empty_next, underflow_next;

    // RAM address is simply the low bits of the registered binary pointer
    assign rd_addr = rd_bin[ADDR_WIDTH-1:0];

    // Next-state: leave INIT once the source domain releases us, never go back
    always_comb begin
        state_next = state;
        case (state)
            INIT:    if (domain_ready) state_next = ACTIVE;
            ACTIVE:  state_next = ACTIVE;
            default: state_next = INIT;
        endcase
    end

    // Gray-to-binary of the write pointer: bit i is the XOR of all bits at or above i
    always_comb begin
        wr_bin = '0;
        for (int i = 0; i < PW; i++) begin
            wr_bin[i] = ^(wr_gray_synced >> i);
        end
    end

    // Pointer advance and next-cycle flags, evaluated against the post-read pointer.
    // Flags are also computed on the INIT->ACTIVE edge so they are valid on the
    // first ACTIVE cycle without an extra bubble.
    always_comb begin
        rd_fire           = (state == ACTIVE) && rd_en && !empty;
        rd_bin_next       = rd_bin + {{(PW-1){1'b0}}, rd_fire};
        rd_gray_next      = (rd_bin_next >> 1) ^ rd_bin_next;
        empty_next        = 1'b1;
        almost_empty_next = 1'b1;
        count_next        = '0;
        underflow_next    = underflow || ((state == ACTIVE) && rd_en && empty);
        if (state_next == ACTIVE) begin
            empty_next        = (rd_gray_next == wr_gray_synced);
            count_next        = wr_bin - rd_bin_next;
            almost_empty_next = (int'(count_next) <= ALMOST_EMPTY_THRESH);
        end
    end

    // State register
    always_ff @(posedge dst_clk or posedge dst_reset) begin
        if (dst_reset) state <= INIT;
        else           state <= state_next;
    end

    // Pointer, flag and occupancy registers
    always_ff @(posedge dst_clk or posedge dst_reset) begin
        if (dst_reset) begin
            rd_bin       <= '0;
            rd_gray      <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            rd_count     <= '0;
            underflow    <= 1'b0;
        end else begin
            rd_bin       <= rd_bin_next;
            rd_gray      <= rd_gray_next;
            empty        <= empty_next;
            almost_empty <= almost_empty_next;
            rd_count     <= count_next;
            underflow    <= underflow_next;
        end
    end

endmodule

// File: tb/tb_enduro_rd_ptr_empty.sv
// Directed bench for enduro_rd_ptr_empty: vector table plus hand sequences
// for async reset, full-depth occupancy and long wrapping read streams.
module tb_enduro_rd_ptr_empty;

    logic       dst_clk = 1'b0;
    logic       dst_reset;
    logic       domain_ready;
    logic [4:0] wr_gray_synced;
    logic       rd_en;
    logic [3:0] rd_addr;
    logic [4:0] rd_gray;
    logic       empty, almost_empty, underflow;
    logic [4:0] rd_count;

    int checks = 0;
    int errors = 0;

    enduro_rd_ptr_empty #(.ADDR_WIDTH(4), .ALMOST_EMPTY_THRESH(2)) dut (
        .dst_clk        (dst_clk),
        .dst_reset      (dst_reset),
        .domain_ready   (domain_ready),
        .wr_gray_synced (wr_gray_synced),
        .rd_en          (rd_en),
        .rd_addr        (rd_addr),
        .rd_gray        (rd_gray),
        .empty          (empty),
        .almost_empty   (almost_empty),
        .rd_count       (rd_count),
        .underflow      (underflow)
    );

    always #5 dst_clk = ~dst_clk;

    typedef struct {
        logic       rdy;
        logic [4:0] wg;
        logic       re;
        logic [3:0] e_addr;
        logic       e_empty;
        logic [4:0] e_cnt;
        logic       e_ae;
        logic       e_uf;
    } vec_t;

    vec_t vecs[20];

    function automatic logic [4:0] gray(input logic [4:0] b);
        return (b >> 1) ^ b;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge dst_clk);
        @(negedge dst_clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_addr"},  rd_addr, 0);
        chk({tag, "_gray"},  rd_gray, 0);
        chk({tag, "_empty"}, empty, 1);
        chk({tag, "_ae"},    almost_empty, 1);
        chk({tag, "_cnt"},   rd_count, 0);
        chk({tag, "_uf"},    underflow, 0);
    endtask

    logic [4:0] model_rd;
    logic [4:0] prev_gray;
    logic       saw_wrap;

    initial begin
        // INIT phase: reads ignored while domain_ready is low
        for (int i = 0; i < 10; i++)
            vecs[i] = '{1'b0, 5'b00011, 1'b1, 4'd0, 1'b1, 5'd0, 1'b1, 1'b0};
        // Release with 3 entries; two idle cycles to settle
        vecs[10] = '{1'b1, 5'b00010, 1'b0, 4'd0, 1'b0, 5'd3, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 5'b00010, 1'b0, 4'd0, 1'b0, 5'd3, 1'b0, 1'b0};
        // Drain: three good reads, then one underflow
        vecs[12] = '{1'b1, 5'b00010, 1'b1, 4'd1, 1'b0, 5'd2, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 5'b00010, 1'b1, 4'd2, 1'b0, 5'd1, 1'b1, 1'b0};
        vecs[14] = '{1'b1, 5'b00010, 1'b1, 4'd3, 1'b1, 5'd0, 1'b1, 1'b0};
        vecs[15] = '{1'b1, 5'b00010, 1'b1, 4'd3, 1'b1, 5'd0, 1'b1, 1'b1};
        vecs[16] = '{1'b1, 5'b00010, 1'b0, 4'd3, 1'b1, 5'd0, 1'b1, 1'b1};
        // Write of Gray(4) arrives, occupancy 1
        vecs[17] = '{1'b1, 5'b00110, 1'b0, 4'd3, 1'b0, 5'd1, 1'b1, 1'b1};
        // Read and write Gray(5) in the same cycle: stays at 1, not empty
        vecs[18] = '{1'b1, 5'b00111, 1'b1, 4'd4, 1'b0, 5'd1, 1'b1, 1'b1};
        vecs[19] = '{1'b1, 5'b00111, 1'b1, 4'd5, 1'b1, 5'd0, 1'b1, 1'b1};

        dst_reset = 1'b1;
        domain_ready = 1'b0;
        wr_gray_synced = 5'b00011;
        rd_en = 1'b0;
        #3;
        chk_reset_vals("por");
        @(negedge dst_clk);
        dst_reset = 1'b0;

        foreach (vecs[i]) begin
            domain_ready   = vecs[i].rdy;
            wr_gray_synced = vecs[i].wg;
            rd_en          = vecs[i].re;
            step();
            chk($sformatf("v%0d_addr", i),  rd_addr, vecs[i].e_addr);
            chk($sformatf("v%0d_empty", i), empty, vecs[i].e_empty);
            chk($sformatf("v%0d_cnt", i),   rd_count, vecs[i].e_cnt);
            chk($sformatf("v%0d_ae", i),    almost_empty, vecs[i].e_ae);
            chk($sformatf("v%0d_uf", i),    underflow, vecs[i].e_uf);
        end

        // Occupancy 5 with underflow set, then async reset between edges
        rd_en = 1'b0;
        wr_gray_synced = gray(5'd10);
        step();
        chk("pre_rst_cnt", rd_count, 5);
        chk("pre_rst_uf", underflow, 1);
        #2 dst_reset = 1'b1;
        #1;
        chk_reset_vals("async");
        @(negedge dst_clk);
        dst_reset = 1'b0;
        // Still INIT: occupancy must not appear without domain_ready
        domain_ready = 1'b0;
        rd_en = 1'b1;
        step();
        chk("post_rst_init_empty", empty, 1);
        chk("post_rst_init_cnt", rd_count, 0);
        chk("post_rst_init_addr", rd_addr, 0);

        // Full FIFO: Gray(16) from rd_bin=0
        rd_en = 1'b0;
        domain_ready = 1'b1;
        wr_gray_synced = gray(5'd16);
        step();
        step();
        chk("full_cnt", rd_count, 16);
        chk("full_empty", empty, 0);
        chk("full_ae", almost_empty, 0);
        for (int k = 1; k <= 14; k++) begin
            rd_en = 1'b1;
            step();
            chk($sformatf("drain%0d_cnt", k), rd_count, 16 - k);
            chk($sformatf("drain%0d_ae", k), almost_empty, (16 - k) <= 2);
        end
        chk("drain_addr", rd_addr, 14);
        chk("drain_empty", empty, 0);

        // Continuous reads with writer staying ahead; pointer wraps 31->0
        model_rd  = 5'd14;
        prev_gray = rd_gray;
        saw_wrap  = 1'b0;
        for (int k = 0; k < 40; k++) begin
            wr_gray_synced = gray(model_rd + 5'd5);
            rd_en = 1'b1;
            step();
            model_rd = model_rd + 5'd1;
            if (model_rd == 5'd0) saw_wrap = 1'b1;
            chk($sformatf("s%0d_addr", k), rd_addr, model_rd[3:0]);
            chk($sformatf("s%0d_gray", k), rd_gray, gray(model_rd));
            chk($sformatf("s%0d_onebit", k), $countones(rd_gray ^ prev_gray), 1);
            chk($sformatf("s%0d_cnt", k), rd_count, 4);
            chk($sformatf("s%0d_empty", k), empty, 0);
            prev_gray = rd_gray;
        end
        chk("stream_wrapped", saw_wrap, 1);
        chk("stream_uf", underflow, 0);

        rd_en = 1'b0;
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time bound so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/enduro_rd_ptr_empty.md
ENDURO_RD_PTR_EMPTY -- requirements
Module: enduro_rd_ptr_empty

Interface
REQ-001 Parameter ADDR_WIDTH, default 4; FIFO depth is 2**ADDR_WIDTH entries.
REQ-002 Parameter ALMOST_EMPTY_THRESH, default 2; almost_empty asserts when the occupancy is at or below this value.
REQ-003 dst_clk  input  1  read-domain clock; all state updates on its rising edge.
REQ-004 dst_reset  input  1  asynchronous, active-high reset; assertion acts immediately, deassertion is synchronous to dst_clk.
REQ-005 domain_ready  input  1  synchronized release signal from the source-domain synchronizer; already in the dst_clk domain.
REQ-006 wr_gray_synced  input  ADDR_WIDTH+1  write pointer in Gray code, already double-synchronized to dst_clk.
REQ-007 rd_en  input  1  read request for the current cycle.
REQ-008 rd_addr  output  ADDR_WIDTH  RAM read address, equal to the low ADDR_WIDTH bits of the binary read pointer.
REQ-009 rd_gray  output  ADDR_WIDTH+1  registered Gray-coded read pointer, exported for synchronization to the write domain.
REQ-010 empty  output  1  registered FIFO-empty flag.
REQ-011 almost_empty  output  1  registered low-occupancy flag.
REQ-012 rd_count  output  ADDR_WIDTH+1  registered occupancy as seen from the read domain, range 0 to 2**ADDR_WIDTH.
REQ-013 underflow  output  1  sticky error flag for a read attempted while empty.

Function
REQ-014 Two-state FSM: INIT and ACTIVE; the block leaves INIT for ACTIVE on the first rising edge where domain_ready=1 and stays in ACTIVE until dst_reset.
REQ-015 In INIT, rd_en is ignored, all pointers hold, empty=1, almost_empty=1, rd_count=0, and underflow is not set.
REQ-016 A read is accepted (rd_fire) when state=ACTIVE, rd_en=1 and empty=0.
REQ-017 On rd_fire, the binary read pointer rd_bin (ADDR_WIDTH+1 bits) increments by 1 modulo 2**(ADDR_WIDTH+1), with natural wrap and no saturation.
REQ-018 rd_addr is updated in the same edge as rd_bin, so the new address is visible one cycle after rd_fire.
REQ-019 rd_gray is registered as (rd_bin_next >> 1) ^ rd_bin_next; exactly one bit of rd_gray changes per accepted read, including on wrap.
REQ-020 empty is registered as (rd_gray_next == wr_gray_synced) while in ACTIVE; a read that consumes the last entry asserts empty on the following cycle, with no bubble.
REQ-021 wr_bin is the combinational Gray-to-binary conversion of wr_gray_synced (XOR prefix from the MSB).
REQ-022 rd_count is registered as (wr_bin - rd_bin_next) modulo 2**(ADDR_WIDTH+1).
REQ-023 almost_empty is registered as (count_next <= ALMOST_EMPTY_THRESH).
REQ-024 If rd_en=1 while empty=1 in ACTIVE, underflow sets to 1 on the next edge; the pointers do not move; only dst_reset clears underflow.
REQ-025 A write-pointer change and a read in the same cycle are both reflected in the next-cycle flags and count, evaluated against the post-read pointer.
REQ-026 The flags are conservative: empty may stay asserted up to the synchronizer latency after a write, but it shall never deassert while the occupancy is 0.

Reset
REQ-027 On dst_reset=1, asynchronously: state=INIT, rd_bin=0, rd_addr=0, rd_gray=0, empty=1, almost_empty=1, rd_count=0, underflow=0.
REQ-028 After dst_reset deasserts, the block stays in INIT until domain_ready=1 is sampled.
REQ-029 Reset asserted mid-transfer discards any in-flight read; no partial pointer update is visible.

Verification
REQ-030 Reset, domain_ready=0, wr_gray_synced=5'b00011, rd_en=1 for 10 cycles -> rd_addr=0, empty=1, underflow=0 throughout.
REQ-031 domain_ready=1, wr_gray_synced=Gray(3)=5'b00010, rd_en=1 for 4 cycles -> rd_addr 1,2,3 then holds; rd_count 2,1,0; empty rises after the 3rd read; underflow=1 after the 4th.
REQ-032 With wr_gray_synced stepped to keep the FIFO non-empty, issue 40 continuous reads -> rd_bin wraps 31->0, each rd_gray transition differs by exactly one bit, rd_addr wraps 15->0.
REQ-033 With wr_gray_synced=Gray(16) and rd_bin=0 -> rd_count=16, empty=0, almost_empty=0; after 14 reads, almost_empty=1 and rd_count=2.
REQ-034 Advance wr_gray_synced by 1 in the same cycle as a read with occupancy 1 -> next cycle empty=0, rd_count=1.
REQ-035 Assert dst_reset asynchronously between edges with rd_count=5 and underflow=1 -> outputs match REQ-027 immediately without a clock edge; state returns to INIT.
